endpoint_flit_tx: RTL and testbench

//  Credit-based flit transmitter driving one switch input port (the switch's data_ready_in/in pair).

---
 rtl/endpoint_flit_tx.sv | 175 +++++++++++++++++
 tb/tb_endpoint_flit_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/endpoint_flit_tx.sv
// Credit-based flit transmitter: accepts endpoint flits over valid/ready and drives one
// switch input port, tracking per-VC credits and unacknowledged packets.
module endpoint_flit_tx #(
    parameter int NUM_VCS         = 2,
    parameter int BUFFER_SIZE     = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int DATA_W          = 16,
    parameter int VC_W            = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1,
    parameter int CW              = $clog2(BUFFER_SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       tx_valid,
    input  logic [DATA_W+VC_W-1:0]     tx_flit,
    input  logic                       tx_last,
    output logic                       tx_ready,
    output logic [DATA_W+VC_W-1:0]     out,
    output logic                       data_ready_out,
    input  logic [NUM_VCS-1:0]         credit_granted,
    input  logic                       packet_sent,
    output logic [NUM_VCS*CW-1:0]      credits,
    output logic                       busy,
    output logic                       credit_error
);

    localparam int FLIT_W = DATA_W + VC_W;
    localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(BUFFER_SIZE);
    localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_r;
    logic [VC_W-1:0]     cur_vc_r;
    logic [OW-1:0]       outst_r;
    logic [CW-1:0]       cred_r     [NUM_VCS];
    logic [CW-1:0]       cred_nxt_s [NUM_VCS];
    logic [NUM_VCS-1:0]  cred_ovf_s;
    logic [NUM_VCS-1:0]  send_vc_s;
    logic                credit_error_r;
    logic                data_ready_r;
    logic [FLIT_W-1:0]   out_r;

    logic [VC_W-1:0]     head_vc_s;
    logic [VC_W-1:0]     sel_vc_s;
    logic                credit_ok_s;
    logic                tx_ready_s;
    logic                accept_s;
    logic                spurious_ack_s;
    logic [OW-1:0]       outst_nxt_s;

    // Ready decode: the VC in play is the locked one mid-packet, else the head's own field.
    always_comb begin
        head_vc_s   = tx_flit[FLIT_W-1 -: VC_W];
        credit_ok_s = 1'b0;
        if (state_r == SEND) begin
            sel_vc_s = cur_vc_r;
        end else begin
            sel_vc_s = head_vc_s;
        end
        for (int v = 0; v < NUM_VCS; v++) begin
            if (sel_vc_s == VC_W'(v)) begin
                credit_ok_s = (cred_r[v] != {CW{1'b0}});
            end else begin
                credit_ok_s = credit_ok_s;
            end
        end
        if (!n_rst) begin
            tx_ready_s = 1'b0;
        end else if (state_r == SEND) begin
            tx_ready_s = credit_ok_s;
        end else begin
            tx_ready_s = credit_ok_s && (outst_r < OUT_MAX);
        end
        accept_s = tx_valid && tx_ready_s;
    end

    // Per-VC credit next state; a return on a full counter saturates and is flagged.
    always_comb begin
        for (int v = 0; v < NUM_VCS; v++) begin
            send_vc_s[v]  = accept_s && (sel_vc_s == VC_W'(v));
            cred_ovf_s[v] = 1'b0;
            cred_nxt_s[v] = cred_r[v];
            case ({send_vc_s[v], credit_granted[v]})
                2'b10: begin
                    cred_nxt_s[v] = cred_r[v] - CW'(1);
                end
                2'b01: begin
                    if (cred_r[v] >= CRED_MAX) begin
                        cred_nxt_s[v] = CRED_MAX;
                        cred_ovf_s[v] = 1'b1;
                    end else begin
                        cred_nxt_s[v] = cred_r[v] + CW'(1);
                    end
                end
                default: begin
                    cred_nxt_s[v] = cred_r[v];
                end
            endcase
        end
    end

    // Outstanding-packet count; an acknowledgement with nothing outstanding is dropped.
    always_comb begin
        spurious_ack_s = packet_sent && (outst_r == {OW{1'b0}});
        case ({accept_s && tx_last, packet_sent && !spurious_ack_s})
            2'b10:   outst_nxt_s = outst_r + OW'(1);
            2'b01:   outst_nxt_s = outst_r - OW'(1);
            default: outst_nxt_s = outst_r;
        endcase
    end

    // FSM, credit/outstanding state and registered link outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r        <= IDLE;
            cur_vc_r       <= {VC_W{1'b0}};
            outst_r        <= {OW{1'b0}};
            credit_error_r <= 1'b0;
            data_ready_r   <= 1'b0;
            out_r          <= {FLIT_W{1'b0}};
            for (int v = 0; v < NUM_VCS; v++) begin
                cred_r[v] <= CRED_MAX;
            end
        end else begin
            for (int v = 0; v < NUM_VCS; v++) begin
                cred_r[v] <= cred_nxt_s[v];
            end
            outst_r      <= outst_nxt_s;
            data_ready_r <= accept_s;
            if ((|cred_ovf_s) || spurious_ack_s) begin
                credit_error_r <= 1'b1;
            end
            if (accept_s) begin
                out_r <= {sel_vc_s, tx_flit[DATA_W-1:0]};
            end
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cur_vc_r <= head_vc_s;
                        if (!tx_last) begin
                            state_r <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (accept_s && tx_last) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Flatten the credit counters onto the status port.
    always_comb begin
        credits = {(NUM_VCS*CW){1'b0}};
        for (int v = 0; v < NUM_VCS; v++) begin
            credits[v*CW +: CW] = cred_r[v];
        end
    end

    assign tx_ready       = tx_ready_s;
    assign out            = out_r;
    assign data_ready_out = data_ready_r;
    assign credit_error   = credit_error_r;
    assign busy           = (state_r == SEND) || (outst_r != {OW{1'b0}});

endmodule

// File: tb/tb_endpoint_flit_tx.sv
// Scoreboard bench for endpoint_flit_tx: directed packets push expected link flits,
// a negedge monitor pops and compares every data_ready_out pulse.
module tb_endpoint_flit_tx;

    localparam int NUM_VCS = 2;
    localparam int DATA_W  = 16;
    localparam int VC_W    = 1;
    localparam int CW      = 4;
    localparam int FW      = DATA_W + VC_W;

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 tx_valid;
    logic [FW-1:0]        tx_flit;
    logic                 tx_last;
    logic                 tx_ready;
    logic [FW-1:0]        out;
    logic                 data_ready_out;
    logic [NUM_VCS-1:0]   credit_granted;
    logic                 packet_sent;
    logic [NUM_VCS*CW-1:0] credits;
    logic                 busy;
    logic                 credit_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int emit_cnt = 0;
    int emit_cyc[$];
    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] exp_f;
    int acc_cyc;

    endpoint_flit_tx #(
        .NUM_VCS(2), .BUFFER_SIZE(8), .MAX_OUTSTANDING(4), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .n_rst(n_rst), .tx_valid(tx_valid), .tx_flit(tx_flit),
        .tx_last(tx_last), .tx_ready(tx_ready), .out(out),
        .data_ready_out(data_ready_out), .credit_granted(credit_granted),
        .packet_sent(packet_sent), .credits(credits), .busy(busy),
        .credit_error(credit_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every link flit must match the head of the scoreboard.
    always @(negedge clk) begin
        if (data_ready_out) begin
            emit_cyc.push_back(cyc);
            emit_cnt++;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_flit got=%h expected none", out);
            end else begin
                exp_f = sb_q.pop_front();
                if (out !== exp_f) begin
                    bad++;
                    $display("FAIL link_flit got=%h expected=%h", out, exp_f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int cred(input int v);
        return int'(credits[v*CW +: CW]);
    endfunction

    // Offer one flit, wait (bounded) for acceptance, then push its expected link image.
    task automatic send_flit(input logic vc, input logic [15:0] data, input logic last,
                             input logic exp_vc);
        int n;
        tx_valid = 1'b1;
        tx_flit  = {vc, data};
        tx_last  = last;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!tx_ready) begin
            bad++;
            $display("FAIL accept_timeout got=not_ready expected=ready data=%h", data);
        end else begin
            sb_q.push_back({exp_vc, data});
        end
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        acc_cyc  = cyc;
    endtask

    task automatic pulse_ack(input int n);
        @(posedge clk);
        #1 packet_sent = 1'b1;
        repeat (n) @(posedge clk);
        #1 packet_sent = 1'b0;
    endtask

    task automatic pulse_credit(input logic [1:0] mask, input int n);
        @(posedge clk);
        #1 credit_granted = mask;
        repeat (n) @(posedge clk);
        #1 credit_granted = 2'b00;
    endtask

    initial begin
        int e0;
        int a0;
        int pulse_c;

        n_rst = 1'b0;
        tx_valid = 1'b1;
        tx_flit = {FW{1'b0}};
        tx_last = 1'b0;
        credit_granted = 2'b00;
        packet_sent = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_ready_low", tx_ready, 0);
        chk("rst_dro", data_ready_out, 0);
        chk("rst_out", int'(out), 0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(negedge clk);
        chk("rst_cred0", cred(0), 8);
        chk("rst_cred1", cred(1), 8);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_credit_error", credit_error, 0);
        tx_valid = 1'b0;

        // Back-to-back 3-flit packet on VC1; body vc fields deliberately 0
        @(posedge clk);
        #1;
        e0 = emit_cnt;
        send_flit(1'b1, 16'h0011, 1'b0, 1'b1);
        a0 = acc_cyc;
        send_flit(1'b0, 16'h0022, 1'b0, 1'b1);
        send_flit(1'b0, 16'h0033, 1'b1, 1'b1);
        @(negedge clk);
        chk("b2b_cred1", cred(1), 5);
        chk("b2b_cred0", cred(0), 8);
        chk("b2b_busy_outstanding", busy, 1);
        repeat (2) @(negedge clk);
        chk("b2b_count", emit_cnt - e0, 3);
        if (emit_cnt - e0 >= 3) begin
            chk("b2b_first_latency", emit_cyc[e0], a0);
            chk("b2b_span", emit_cyc[e0+2] - emit_cyc[e0], 2);
        end
        pulse_ack(1);
        @(negedge clk);
        chk("b2b_busy_after_ack", busy, 0);
        pulse_credit(2'b10, 3);
        @(negedge clk);
        chk("b2b_cred1_restored", cred(1), 8);
        chk("b2b_no_error", credit_error, 0);

        // Credit stall: 10-flit packet on VC0
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            send_flit(1'b0, 16'h0100 + 16'(i), 1'b0, 1'b0);
        end
        tx_valid = 1'b1;
        tx_flit  = {1'b1, 16'h0108};
        tx_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", tx_ready, 0);
        end
        chk("stall_cred0", cred(0), 0);
        @(posedge clk);
        #1 credit_granted = 2'b01;
        pulse_c = cyc;
        @(negedge clk);
        chk("stall_pulse_cycle_ready", tx_ready, 0);
        @(posedge clk);
        #1 credit_granted = 2'b00;
        sb_q.push_back({1'b0, 16'h0108});
        @(negedge clk);
        chk("stall_resume_ready", tx_ready, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_emit_delay", emit_cyc[emit_cnt-1] - pulse_c, 2);
        pulse_credit(2'b01, 1);
        send_flit(1'b1, 16'h0109, 1'b1, 1'b0);
        @(negedge clk);
        chk("stall_cred0_end", cred(0), 0);
        chk("stall_cred1_untouched", cred(1), 8);
        pulse_ack(1);
        pulse_credit(2'b01, 8);
        @(negedge clk);
        chk("stall_cred0_refill", cred(0), 8);
        chk("stall_busy", busy, 0);
        chk("stall_no_error", credit_error, 0);

        // Simultaneous send and return on VC0, then overflow at full
        @(posedge clk);
        #1 credit_granted = 2'b01;
        send_flit(1'b0, 16'h0200, 1'b1, 1'b0);
        credit_granted = 2'b00;
        @(negedge clk);
        chk("simul_cred0", cred(0), 8);
        chk("simul_no_error", credit_error, 0);
        pulse_ack(1);
        pulse_credit(2'b01, 1);
        @(negedge clk);
        chk("ovf_cred0", cred(0), 8);
        chk("ovf_credit_error", credit_error, 1);

        // Outstanding limit: fifth single-flit head must stall until an ack
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            send_flit(1'b1, 16'h0300 + 16'(i), 1'b1, 1'b1);
        end
        tx_valid = 1'b1;
        tx_flit  = {1'b1, 16'h0304};
        tx_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("limit_ready", tx_ready, 0);
        end
        chk("limit_busy", busy, 1);
        @(posedge clk);
        #1 packet_sent = 1'b1;
        @(negedge clk);
        chk("limit_ack_cycle_ready", tx_ready, 0);
        @(posedge clk);
        #1 packet_sent = 1'b0;
        sb_q.push_back({1'b1, 16'h0304});
        @(negedge clk);
        chk("limit_release_ready", tx_ready, 1);
        @(posedge clk);
        #1 tx_valid = 1'b0;
        tx_last = 1'b0;
        @(negedge clk);
        chk("limit_cred1", cred(1), 3);
        chk("limit_error_sticky", credit_error, 1);
        pulse_ack(3);
        @(negedge clk);
        chk("limit_busy_one_left", busy, 1);
        pulse_ack(1);
        @(negedge clk);
        chk("limit_busy_drained", busy, 0);

        // Reset mid-packet after 2 of 4 flits
        @(posedge clk);
        #1;
        e0 = emit_cnt;
        send_flit(1'b0, 16'h0400, 1'b0, 1'b0);
        send_flit(1'b0, 16'h0401, 1'b0, 1'b0);
        tx_valid = 1'b1;
        tx_flit  = {1'b0, 16'h0402};
        n_rst    = 1'b0;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_rst_emits", emit_cnt - e0, 2);
        chk("mid_rst_dro", data_ready_out, 0);
        chk("mid_rst_cred0", cred(0), 8);
        chk("mid_rst_cred1", cred(1), 8);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_error", credit_error, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
